// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, redirect flush, data-memory wait freeze
//
// Parameters:
//   MEM_TIMEOUT  max consecutive MEM_WAIT cycles before the wait is abandoned (1..65535)
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   ID_opcode/ID_rs1/ID_rs2            instruction currently in ID
//   EX_opcode/EX_rd                    instruction currently in EX
//   EX_br_taken                        EX redirects the PC this cycle
//   ME_dmem_req/ME_dmem_ready          ME data access pending / completing this cycle
//   PC_stall..EX_ME_stall              hold the corresponding stage register
//   IF_ID_flush/ID_EX_bubble/ME_WB_bubble  load a NOP into the stage register
//   mem_timeout                        sticky flag, set when a memory wait is abandoned
// Optional build macro:
//   HAZARD_PERF_CNT_EN  adds lu_stall_cnt, mem_stall_cnt, flush_cnt (32-bit event counters)
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  ID_opcode,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [6:0]  EX_opcode,
  input  logic [4:0]  EX_rd,
  input  logic        EX_br_taken,
  input  logic        ME_dmem_req,
  input  logic        ME_dmem_ready,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        ID_EX_stall,
  output logic        EX_ME_stall,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        ME_WB_bubble,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_LU_HOLD  = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [15:0] LP_TIMEOUT = 16'(MEM_TIMEOUT);

  logic [1:0]  r_state;
  logic [15:0] r_to_cnt;
  logic        r_mem_timeout;

  logic [1:0]  w_next_state;
  logic [15:0] w_to_cnt_next;
  logic        w_set_timeout;
  logic        w_freeze;
  logic        w_redirect;
  logic        w_lu_fire;
  logic        w_mem_stall;
  logic        w_producer_nofwd;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic        w_lu_hazard;

  // Load and link results only exist after ME, so they cannot be forwarded to ID in time.
  assign w_producer_nofwd = ((EX_opcode == OP_LOAD) || (EX_opcode == OP_JAL) ||
                             (EX_opcode == OP_JALR)) && (EX_rd != 5'd0);
  assign w_uses_rs1  = !((ID_opcode == OP_LUI) || (ID_opcode == OP_AUIPC) || (ID_opcode == OP_JAL));
  assign w_uses_rs2  = (ID_opcode == OP_REG) || (ID_opcode == OP_STORE) || (ID_opcode == OP_BRANCH);
  assign w_lu_hazard = w_producer_nofwd &&
                       ((w_uses_rs1 && (ID_rs1 == EX_rd)) || (w_uses_rs2 && (ID_rs2 == EX_rd)));
  assign w_mem_stall = ME_dmem_req && !ME_dmem_ready;

  always_comb begin
    w_next_state  = S_RUN;
    w_to_cnt_next = 16'd0;
    w_set_timeout = 1'b0;
    w_freeze      = 1'b0;
    w_redirect    = 1'b0;
    w_lu_fire     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_MEM_WAIT: begin
          if (ME_dmem_ready) begin
            w_next_state = S_RUN;
          end else if (r_to_cnt == LP_TIMEOUT) begin
            // Abandon the access: release the pipeline and flag the error.
            w_set_timeout = 1'b1;
          end else begin
            w_freeze      = 1'b1;
            w_next_state  = S_MEM_WAIT;
            w_to_cnt_next = (r_to_cnt == 16'hFFFF) ? r_to_cnt : r_to_cnt + 16'd1;
          end
        end
        default: begin
          // RUN and LU_HOLD share this path; LU_HOLD only masks the load-use check
          // because EX already carries the bubble inserted on the previous cycle.
          if (w_mem_stall) begin
            w_freeze      = 1'b1;
            w_next_state  = S_MEM_WAIT;
            w_to_cnt_next = 16'd1;
          end else if (EX_br_taken) begin
            w_redirect = 1'b1;
          end else if (w_lu_hazard && (r_state == S_RUN)) begin
            w_lu_fire    = 1'b1;
            w_next_state = S_LU_HOLD;
          end
        end
      endcase
    end
  end

  assign PC_stall     = w_freeze | w_lu_fire;
  assign IF_ID_stall  = w_freeze | w_lu_fire;
  assign ID_EX_stall  = w_freeze;
  assign EX_ME_stall  = w_freeze;
  assign ME_WB_bubble = w_freeze;
  assign IF_ID_flush  = w_redirect;
  assign ID_EX_bubble = w_redirect | w_lu_fire;
  assign mem_timeout  = r_mem_timeout & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_RUN;
      r_to_cnt      <= 16'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_to_cnt <= w_to_cnt_next;
      if (w_set_timeout) begin
        r_mem_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_lu_stall_cnt;
  logic [31:0] r_mem_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lu_stall_cnt  <= 32'd0;
      r_mem_stall_cnt <= 32'd0;
      r_flush_cnt     <= 32'd0;
    end else begin
      if (w_lu_fire) r_lu_stall_cnt  <= r_lu_stall_cnt + 32'd1;
      if (w_freeze)  r_mem_stall_cnt <= r_mem_stall_cnt + 32'd1;
      if (w_redirect) r_flush_cnt    <= r_flush_cnt + 32'd1;
    end
  end

  assign lu_stall_cnt  = r_lu_stall_cnt;
  assign mem_stall_cnt = r_mem_stall_cnt;
  assign flush_cnt     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] OPI    = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  // expected output order: {PC, IF_ID_st, ID_EX_st, EX_ME_st, IF_ID_flush, ID_EX_bub, ME_WB_bub, mem_timeout}
  localparam logic [7:0] E_NONE = 8'b0000_0000;
  localparam logic [7:0] E_FRZ  = 8'b1111_0010;
  localparam logic [7:0] E_LU   = 8'b1100_0100;
  localparam logic [7:0] E_RED  = 8'b0000_1100;
  localparam logic [7:0] E_TO   = 8'b0000_0001;

  logic clk = 1'b0;
  logic reset;
  logic [6:0] ID_opcode;
  logic [4:0] ID_rs1, ID_rs2;
  logic [6:0] EX_opcode;
  logic [4:0] EX_rd;
  logic EX_br_taken, ME_dmem_req, ME_dmem_ready;
  logic PC_stall, IF_ID_stall, ID_EX_stall, EX_ME_stall;
  logic IF_ID_flush, ID_EX_bubble, ME_WB_bubble, mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .ID_opcode(ID_opcode), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .EX_opcode(EX_opcode), .EX_rd(EX_rd), .EX_br_taken(EX_br_taken),
    .ME_dmem_req(ME_dmem_req), .ME_dmem_ready(ME_dmem_ready),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
    .EX_ME_stall(EX_ME_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_bubble(ID_EX_bubble),
    .ME_WB_bubble(ME_WB_bubble), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] idop;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] exop;
    logic [4:0] rd;
    logic       br;
    logic       req;
    logic       rdy;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(string name, logic rst, logic [6:0] idop, logic [4:0] rs1,
                              logic [4:0] rs2, logic [6:0] exop, logic [4:0] rd,
                              logic br, logic req, logic rdy, logic [7:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.idop = idop; v.rs1 = rs1; v.rs2 = rs2;
    v.exop = exop; v.rd = rd; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {PC_stall, IF_ID_stall, ID_EX_stall, EX_ME_stall,
            IF_ID_flush, ID_EX_bubble, ME_WB_bubble, mem_timeout};
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic apply(vec_t v);
    reset = v.rst; ID_opcode = v.idop; ID_rs1 = v.rs1; ID_rs2 = v.rs2;
    EX_opcode = v.exop; EX_rd = v.rd; EX_br_taken = v.br;
    ME_dmem_req = v.req; ME_dmem_ready = v.rdy;
  endtask

  initial begin
    int  n_frz;
    bit  dropped;

    apply(mk("init", 1, OPI, 0, 0, OPI, 0, 0, 0, 0, E_NONE));

    //       name            rst idop    rs1 rs2 exop   rd br req rdy exp
    tv.push_back(mk("rst_all_causes", 1, OPR,    5, 1, LOAD, 5, 1, 1, 0, E_NONE));
    tv.push_back(mk("lu_load_rs1",    0, OPR,    5, 1, LOAD, 5, 0, 0, 0, E_LU));
    tv.push_back(mk("lu_hold_masked", 0, OPR,    5, 1, LOAD, 5, 0, 0, 0, E_NONE));
    tv.push_back(mk("idle",           0, OPI,    1, 2, OPI,  3, 0, 0, 0, E_NONE));
    tv.push_back(mk("load_x0",        0, OPR,    0, 0, LOAD, 0, 0, 0, 0, E_NONE));
    tv.push_back(mk("lui_fwd",        0, OPR,    5, 1, LUI,  5, 0, 0, 0, E_NONE));
    tv.push_back(mk("lu_jal_rs2",     0, STORE,  2, 7, JAL,  7, 0, 0, 0, E_LU));
    tv.push_back(mk("hold_memstall",  0, STORE,  2, 7, JAL,  7, 0, 1, 0, E_FRZ));
    tv.push_back(mk("wait_ready",     0, OPI,    1, 2, OPI,  3, 0, 1, 1, E_NONE));
    tv.push_back(mk("br_over_lu",     0, OPR,    5, 1, LOAD, 5, 1, 0, 0, E_RED));
    tv.push_back(mk("lu_after_br",    0, OPR,    5, 1, LOAD, 5, 0, 0, 0, E_LU));
    tv.push_back(mk("hold_redirect",  0, OPR,    5, 1, LOAD, 5, 1, 0, 0, E_RED));
    tv.push_back(mk("lui_no_rs1",     0, LUI,    5, 0, LOAD, 5, 0, 0, 0, E_NONE));
    tv.push_back(mk("auipc_no_rs1",   0, AUIPC,  5, 5, LOAD, 5, 0, 0, 0, E_NONE));
    tv.push_back(mk("opimm_no_rs2",   0, OPI,    1, 5, JALR, 5, 0, 0, 0, E_NONE));
    tv.push_back(mk("branch_rs2",     0, BRANCH, 1, 5, JALR, 5, 0, 0, 0, E_LU));
    tv.push_back(mk("hold_idle",      0, OPI,    1, 2, OPI,  3, 0, 0, 0, E_NONE));
    tv.push_back(mk("mem_over_all",   0, OPR,    5, 1, LOAD, 5, 1, 1, 0, E_FRZ));
    tv.push_back(mk("wait_2",         0, OPR,    5, 1, LOAD, 5, 1, 1, 0, E_FRZ));
    tv.push_back(mk("wait_3",         0, OPR,    5, 1, LOAD, 5, 1, 1, 0, E_FRZ));
    tv.push_back(mk("wait_rdy_br",    0, OPR,    5, 1, LOAD, 5, 1, 1, 1, E_NONE));
    tv.push_back(mk("br_after_wait",  0, OPI,    1, 2, OPI,  3, 1, 0, 0, E_RED));
    tv.push_back(mk("req_rdy_same",   0, OPI,    1, 2, OPI,  3, 0, 1, 1, E_NONE));
    tv.push_back(mk("enter_wait",     0, OPI,    1, 2, OPI,  3, 0, 1, 0, E_FRZ));
    tv.push_back(mk("rst_in_wait",    1, OPI,    1, 2, OPI,  3, 0, 1, 0, E_NONE));
    tv.push_back(mk("run_after_rst",  0, OPI,    1, 2, OPI,  3, 0, 0, 0, E_NONE));
    tv.push_back(mk("enter_hold",     0, OPR,    5, 1, LOAD, 5, 0, 0, 0, E_LU));
    tv.push_back(mk("rst_in_hold",    1, OPR,    5, 1, LOAD, 5, 0, 0, 0, E_NONE));
    tv.push_back(mk("lu_after_rst",   0, OPR,    5, 1, LOAD, 5, 0, 0, 0, E_LU));
    tv.push_back(mk("to_frz1",        0, OPI,    1, 2, OPI,  3, 0, 1, 0, E_FRZ));
    tv.push_back(mk("to_frz2",        0, OPI,    1, 2, OPI,  3, 0, 1, 0, E_FRZ));
    tv.push_back(mk("to_frz3",        0, OPI,    1, 2, OPI,  3, 0, 1, 0, E_FRZ));
    tv.push_back(mk("to_frz4",        0, OPI,    1, 2, OPI,  3, 0, 1, 0, E_FRZ));
    tv.push_back(mk("to_abort",       0, OPI,    1, 2, OPI,  3, 0, 1, 0, E_NONE));
    tv.push_back(mk("to_sticky",      0, OPI,    1, 2, OPI,  3, 0, 0, 0, E_TO));
    tv.push_back(mk("to_sticky_br",   0, OPI,    1, 2, OPI,  3, 1, 0, 0, E_TO | E_RED));
    tv.push_back(mk("to_rst",         1, OPI,    1, 2, OPI,  3, 0, 0, 0, E_NONE));
    tv.push_back(mk("to_cleared",     0, OPI,    1, 2, OPI,  3, 0, 0, 0, E_NONE));

    @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
    #1;
    check("perf_lu_rst", lu_stall_cnt, 32'd0);
    check("perf_mem_rst", mem_stall_cnt, 32'd0);
    check("perf_flush_rst", flush_cnt, 32'd0);
`endif

    foreach (tv[i]) begin
      @(posedge clk); #1;
      apply(tv[i]);
      @(negedge clk);
      check(tv[i].name, {24'd0, outs()}, {24'd0, tv[i].exp});
    end

    // Timeout walk: count frozen cycles until the controller gives up on its own.
    @(posedge clk); #1;
    apply(mk("walk", 0, OPI, 1, 2, OPI, 3, 0, 1, 0, E_NONE));
    n_frz   = 0;
    dropped = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!dropped) begin
        @(negedge clk);
        if (PC_stall && EX_ME_stall && ME_WB_bubble) n_frz++;
        else dropped = 1'b1;
        if (!dropped) begin
          @(posedge clk); #1;
        end
      end
    end
    check("walk_released", {31'd0, dropped}, 32'd1);
    check("walk_frz_cycles", n_frz, 32'd4);
    @(posedge clk); #1;
    ME_dmem_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("walk_sticky", {24'd0, outs()}, {24'd0, E_TO});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("walk_rst_clear", {31'd0, mem_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_mem_after_rst", mem_stall_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
